// File: rtl/regfile_wr_arbiter.sv
// Single write-port arbiter for the GPR file: write-back wins, long-latency results queue in a FIFO.
// Optional starvation guard (RUN/HOLD pipeline hold) is built only when RF_ARB_STARVE_EN is defined.
module regfile_wr_arbiter #(
    parameter int DW           = 32,
    parameter int AW           = 5,
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wb_we,
    input  logic [AW-1:0] wb_waddr,
    input  logic [DW-1:0] wb_wdata,
    input  logic          lu_valid,
    output logic          lu_ready,
    input  logic [AW-1:0] lu_waddr,
    input  logic [DW-1:0] lu_wdata,
    output logic          rf_we,
    output logic [AW-1:0] rf_waddr,
    output logic [DW-1:0] rf_wdata,
    output logic          stall_req,
    input  logic [AW-1:0] rd_addr1,
    input  logic [AW-1:0] rd_addr2,
    output logic          pend1,
    output logic          pend2
);
    localparam int PW = $clog2(DEPTH);

    logic [PW:0]      wr_ptr_q, rd_ptr_q;
    logic [AW-1:0]    mem_addr_q [DEPTH];
    logic [DW-1:0]    mem_data_q [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic             empty, full, push, pop;
    logic [AW-1:0]    head_addr;
    logic [DW-1:0]    head_data;

    logic             rf_we_q;
    logic [AW-1:0]    rf_waddr_q;
    logic [DW-1:0]    rf_wdata_q;

    // Extra wrap bit distinguishes full from empty when the index bits match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);

    assign lu_ready  = !full;
    assign push      = lu_valid && !full && (lu_waddr != '0);
    assign pop       = !wb_we && !empty;
    assign head_addr = mem_addr_q[rd_ptr_q[PW-1:0]];
    assign head_data = mem_data_q[rd_ptr_q[PW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            vld_q    <= '0;
        end else begin
            if (pop) begin
                rd_ptr_q                  <= rd_ptr_q + {{PW{1'b0}}, 1'b1};
                vld_q[rd_ptr_q[PW-1:0]]   <= 1'b0;
            end
            if (push) begin
                wr_ptr_q                  <= wr_ptr_q + {{PW{1'b0}}, 1'b1};
                vld_q[wr_ptr_q[PW-1:0]]   <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr_q[wr_ptr_q[PW-1:0]] <= lu_waddr;
            mem_data_q[wr_ptr_q[PW-1:0]] <= lu_wdata;
        end
    end

    // Registered grant; address/data hold their last value on idle cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            rf_we_q <= wb_we || pop;
            if (wb_we) begin
                rf_waddr_q <= wb_waddr;
                rf_wdata_q <= wb_wdata;
            end else if (pop) begin
                rf_waddr_q <= head_addr;
                rf_wdata_q <= head_data;
            end
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;

    always_comb begin
        pend1 = 1'b0;
        pend2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && (mem_addr_q[i] == rd_addr1)) pend1 = 1'b1;
            if (vld_q[i] && (mem_addr_q[i] == rd_addr2)) pend2 = 1'b1;
        end
        if (rd_addr1 == '0) pend1 = 1'b0;
        if (rd_addr2 == '0) pend2 = 1'b0;
    end

`ifdef RF_ARB_STARVE_EN
    localparam int CW = $clog2(STARVE_LIMIT) + 1;
    localparam logic [CW-1:0] LIMIT   = CW'(STARVE_LIMIT);
    localparam logic [CW-1:0] TRIGGER = CW'(STARVE_LIMIT - 1);

    typedef enum logic {RUN, HOLD} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
    logic            blocked;

    assign blocked = !empty && wb_we;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Saturated count keeps re-arming HOLD if the pipeline ignores the hold.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        if (empty || pop)
            wait_cnt_d = '0;
        else if (blocked && (wait_cnt_q != LIMIT))
            wait_cnt_d = wait_cnt_q + CW'(1);
        case (state_q)
            RUN:     if (blocked && (wait_cnt_q >= TRIGGER)) state_d = HOLD;
            HOLD:    state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    assign stall_req = (state_q == HOLD);
`else
    assign stall_req = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter with default parameters; starvation
// expectations follow whether RF_ARB_STARVE_EN is defined.
module tb_regfile_wr_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        lu_valid;
    logic        lu_ready;
    logic [4:0]  lu_waddr;
    logic [31:0] lu_wdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        stall_req;
    logic [4:0]  rd_addr1, rd_addr2;
    logic        pend1, pend2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_wr_arbiter dut (
        .clk(clk), .rst(rst),
        .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_waddr(lu_waddr), .lu_wdata(lu_wdata),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .stall_req(stall_req),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .pend1(pend1), .pend2(pend2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to the next cycle; inputs are driven 2 time units after the edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic wb(input logic we, input logic [4:0] a, input logic [31:0] d);
        wb_we = we; wb_waddr = a; wb_wdata = d;
    endtask

    task automatic lu(input logic v, input logic [4:0] a, input logic [31:0] d);
        lu_valid = v; lu_waddr = a; lu_wdata = d;
    endtask

    initial begin
        rst = 1'b1;
        wb(0, 0, 0); lu(0, 0, 0);
        rd_addr1 = 0; rd_addr2 = 0;
        tick(); tick();
        settle();
        chk("rst_rf_we", rf_we, 0);
        chk("rst_rf_waddr", rf_waddr, 0);
        chk("rst_rf_wdata", rf_wdata, 0);
        chk("rst_stall", stall_req, 0);
        chk("rst_lu_ready", lu_ready, 1);
        chk("rst_pend1", pend1, 0);
        rst = 1'b0;
        tick();

        // write-back only
        wb(1, 3, 32'h1234);
        tick();
        wb(0, 0, 0); settle();
        chk("wb_rf_we", rf_we, 1);
        chk("wb_rf_waddr", rf_waddr, 3);
        chk("wb_rf_wdata", rf_wdata, 32'h1234);
        tick(); settle();
        chk("wb_idle_we", rf_we, 0);
        chk("wb_idle_hold_addr", rf_waddr, 3);
        chk("wb_idle_hold_data", rf_wdata, 32'h1234);

        // collision: lu queued behind two write-back cycles
        lu(1, 7, 32'hAA); rd_addr1 = 7; settle();
        chk("col_c0_ready", lu_ready, 1);
        chk("col_c0_pend_no_bypass", pend1, 0);
        tick();
        lu(0, 0, 0); wb(1, 2, 32'h22); settle();
        chk("col_c1_pend", pend1, 1);
        chk("col_c1_rf_we", rf_we, 0);
        tick(); settle();
        chk("col_c2_rf_we", rf_we, 1);
        chk("col_c2_rf_waddr", rf_waddr, 2);
        chk("col_c2_pend", pend1, 1);
        tick();
        wb(0, 0, 0); settle();
        chk("col_c3_rf_waddr", rf_waddr, 2);
        chk("col_c3_pend", pend1, 1);
        tick(); settle();
        chk("col_c4_rf_we", rf_we, 1);
        chk("col_c4_rf_waddr", rf_waddr, 7);
        chk("col_c4_rf_wdata", rf_wdata, 32'hAA);
        chk("col_c4_pend", pend1, 0);
        tick(); settle();
        chk("col_c5_rf_we", rf_we, 0);

        // full / backpressure with write-back busy
        wb(1, 4, 32'h44); lu(1, 9, 32'h91); settle();
        chk("full_f0_ready", lu_ready, 1);
        tick();
        lu(1, 10, 32'hA2); settle();
        chk("full_f1_ready", lu_ready, 1);
        tick();
        lu(1, 11, 32'hB3); rd_addr2 = 10; settle();
        chk("full_f2_ready", lu_ready, 0);
        chk("full_f2_pend2", pend2, 1);
        chk("full_f2_rf_waddr", rf_waddr, 4);
        tick();
        lu(0, 0, 0); wb(0, 0, 0); settle();
        chk("full_f3_ready", lu_ready, 0);
        tick(); settle();
        chk("full_f4_ready", lu_ready, 1);
        chk("full_f4_rf_we", rf_we, 1);
        chk("full_f4_rf_waddr", rf_waddr, 9);
        chk("full_f4_rf_wdata", rf_wdata, 32'h91);
        tick();
        rd_addr1 = 11; settle();
        chk("full_f5_rf_waddr", rf_waddr, 10);
        chk("full_f5_rf_wdata", rf_wdata, 32'hA2);
        chk("full_f5_rejected_not_pend", pend1, 0);
        chk("full_f5_pend2_clear", pend2, 0);
        tick(); settle();
        chk("full_f6_rf_we", rf_we, 0);

        // address 0 is accepted but dropped
        lu(1, 0, 32'hFF); rd_addr1 = 0; rd_addr2 = 0; settle();
        chk("z0_ready", lu_ready, 1);
        tick();
        lu(0, 0, 0); settle();
        chk("z1_pend", pend1, 0);
        chk("z1_rf_we", rf_we, 0);
        tick(); settle();
        chk("z2_rf_we", rf_we, 0);
        chk("z2_rf_waddr", rf_waddr, 10);

        // starvation: one entry, write-back busy every cycle
        lu(1, 12, 32'hC); wb(1, 1, 32'h11);
        tick();
        lu(0, 0, 0);
        for (int s = 1; s <= 4; s++) begin
            settle();
            chk($sformatf("stv_s%0d_stall", s), stall_req, 0);
            tick();
        end
`ifdef RF_ARB_STARVE_EN
        settle();
        chk("stv_s5_stall", stall_req, 1);
        wb(0, 0, 0);
        tick(); settle();
        chk("stv_s6_stall", stall_req, 0);
        chk("stv_s6_rf_we", rf_we, 1);
        chk("stv_s6_rf_waddr", rf_waddr, 12);
        chk("stv_s6_rf_wdata", rf_wdata, 32'hC);
`else
        settle();
        chk("stv_s5_stall", stall_req, 0);
        tick(); settle();
        chk("stv_s6_rf_waddr_wb", rf_waddr, 1);
        wb(0, 0, 0);
        tick(); settle();
        chk("stv_s7_rf_waddr", rf_waddr, 12);
        chk("stv_s7_rf_wdata", rf_wdata, 32'hC);
`endif
        tick(); settle();
        chk("stv_drained_rf_we", rf_we, 0);

        // reset mid-traffic with two entries queued
        wb(1, 6, 32'h66); lu(1, 5, 32'h55);
        tick();
        lu(1, 8, 32'h88);
        tick();
        lu(0, 0, 0); rst = 1'b1; rd_addr1 = 5; settle();
        chk("rstm_pend_before", pend1, 1);
        chk("rstm_ready_before", lu_ready, 0);
        tick(); settle();
        chk("rstm_rf_we", rf_we, 0);
        chk("rstm_rf_waddr", rf_waddr, 0);
        chk("rstm_rf_wdata", rf_wdata, 0);
        chk("rstm_ready", lu_ready, 1);
        chk("rstm_pend", pend1, 0);
        chk("rstm_stall", stall_req, 0);
        tick();
        rst = 1'b0; wb(0, 0, 0);
        tick(); settle();
        chk("rstm_post1_rf_we", rf_we, 0);
        tick(); settle();
        chk("rstm_post2_rf_we", rf_we, 0);
        chk("rstm_post2_pend", pend1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
